// File: rtl/delay_meas.sv
// Round-trip delay meter: launches a probe edge into an external delay line
// once the return path has been quiet, then counts cycles until it comes back.
module delay_meas #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned MAX_DELAY    = 255,
    parameter int unsigned QUIET_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             PROBE_OUT,
    input  logic             PROBE_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] DELAY_OUT
);

    localparam int unsigned FLUSH_LIMIT = MAX_DELAY + QUIET_CYCLES;
    localparam int unsigned QUIET_W     = $clog2(QUIET_CYCLES + 1);
    localparam int unsigned FLUSH_W     = $clog2(FLUSH_LIMIT + 1);

    localparam logic [QUIET_W-1:0] QUIET_TARGET = QUIET_W'(QUIET_CYCLES);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST   = FLUSH_W'(FLUSH_LIMIT - 1);
    localparam logic [CNT_W-1:0]   DELAY_MAX    = CNT_W'(MAX_DELAY);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [QUIET_W-1:0] quiet_cnt;
    logic [QUIET_W-1:0] quiet_cnt_d;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [FLUSH_W-1:0] flush_cnt_d;
    logic [CNT_W-1:0]   delay_cnt;
    logic [CNT_W-1:0]   delay_cnt_d;
    logic               probe_d;
    logic               busy_d;
    logic               done_d;
    logic               timeout_d;
    logic [CNT_W-1:0]   delay_out_d;

    // State register; every output is registered from its *_d value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            quiet_cnt <= '0;
            flush_cnt <= '0;
            delay_cnt <= '0;
            PROBE_OUT <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            TIMEOUT   <= 1'b0;
            DELAY_OUT <= '0;
        end else begin
            state     <= state_d;
            quiet_cnt <= quiet_cnt_d;
            flush_cnt <= flush_cnt_d;
            delay_cnt <= delay_cnt_d;
            PROBE_OUT <= probe_d;
            BUSY      <= busy_d;
            DONE      <= done_d;
            TIMEOUT   <= timeout_d;
            DELAY_OUT <= delay_out_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        quiet_cnt_d = quiet_cnt;
        flush_cnt_d = flush_cnt;
        delay_cnt_d = delay_cnt;
        probe_d     = PROBE_OUT;
        done_d      = 1'b0;
        timeout_d   = TIMEOUT;
        delay_out_d = DELAY_OUT;

        unique case (state)
            IDLE: begin
                probe_d = 1'b0;
                if (START) begin
                    state_d     = FLUSH;
                    quiet_cnt_d = '0;
                    flush_cnt_d = '0;
                    timeout_d   = 1'b0;
                    delay_out_d = '0;
                end
            end

            // Wait for the return path to settle low before launching the edge.
            FLUSH: begin
                probe_d = 1'b0;
                if (quiet_cnt == QUIET_TARGET) begin
                    state_d     = MEASURE;
                    probe_d     = 1'b1;
                    delay_cnt_d = '0;
                end else if (flush_cnt == FLUSH_LAST) begin
                    state_d     = REPORT;
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                    delay_out_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt + FLUSH_W'(1);
                    quiet_cnt_d = PROBE_IN ? '0 : quiet_cnt + QUIET_W'(1);
                end
            end

            // Saturating count: stops at DELAY_MAX and reports a timeout.
            MEASURE: begin
                probe_d = 1'b1;
                if (PROBE_IN) begin
                    state_d     = REPORT;
                    probe_d     = 1'b0;
                    done_d      = 1'b1;
                    delay_out_d = delay_cnt;
                end else if (delay_cnt == DELAY_MAX) begin
                    state_d     = REPORT;
                    probe_d     = 1'b0;
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                    delay_out_d = DELAY_MAX;
                end else begin
                    delay_cnt_d = delay_cnt + CNT_W'(1);
                end
            end

            REPORT: begin
                probe_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                probe_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: doc/delay_meas.md
DELAY_MEAS -- requirements
Module: delay_meas

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the delay counter and of DELAY_OUT.
REQ-002 SHALL have parameter MAX_DELAY, default 255: measurement limit in cycles; legal range 1 to 2^CNT_W-1.
REQ-003 SHALL have parameter QUIET_CYCLES, default 4: consecutive 0 samples required on PROBE_IN before launch; legal range 1 to 255.
REQ-004 SHALL have port CLK  input  1  system clock; all logic updates on its rising edge.
REQ-005 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port START  input  1  measurement request; sampled only in IDLE.
REQ-007 SHALL have port PROBE_OUT  output  1  registered stimulus, driven into the input of the delay line under test.
REQ-008 SHALL have port PROBE_IN  input  1  returned signal, taken from the output of the delay line under test.
REQ-009 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-010 SHALL have port DONE  output  1  single-cycle pulse when a result is valid.
REQ-011 SHALL have port TIMEOUT  output  CNT_W>=1 ? 1 : 1  flag for an aborted measurement; valid together with DONE and held until the next START.
REQ-012 SHALL have port DELAY_OUT  output  CNT_W  measured delay in cycles; valid with DONE and held until the next START.

Function
REQ-013 SHALL implement four states: IDLE, FLUSH, MEASURE, REPORT.
REQ-014 IDLE: PROBE_OUT=0. START=1 moves to FLUSH, clears the quiet counter, and clears TIMEOUT and DELAY_OUT.
REQ-015 FLUSH: PROBE_OUT=0.
  - Each cycle with PROBE_IN=0 increments the quiet counter; each cycle with PROBE_IN=1 clears it.
  - When the quiet counter reaches QUIET_CYCLES: move to MEASURE, set PROBE_OUT=1 on that same edge, and clear the delay counter.
REQ-016 FLUSH timeout: if the state stays in FLUSH for MAX_DELAY+QUIET_CYCLES cycles, move to REPORT with TIMEOUT=1 and DELAY_OUT=0.
REQ-017 MEASURE: PROBE_OUT held at 1. Each cycle:
  - PROBE_IN=1: DELAY_OUT=delay counter; move to REPORT.
  - PROBE_IN=0: delay counter increments by 1.
REQ-018 Delay definition: number of rising edges from the edge that sets PROBE_OUT=1 to the edge that samples PROBE_IN=1, minus one.
  - Combinational loopback reports 0.
  - An N-stage DFF chain reports N.
REQ-019 MEASURE timeout: if PROBE_IN is still 0 when the delay counter equals MAX_DELAY, move to REPORT with TIMEOUT=1 and DELAY_OUT=MAX_DELAY.
  - The counter never exceeds MAX_DELAY and never wraps.
REQ-020 REPORT: lasts exactly one cycle; DONE=1 and PROBE_OUT=0; then move to IDLE.
REQ-021 START SHALL be ignored outside IDLE, including in the REPORT cycle.
  - START held high in IDLE starts a new measurement on the first IDLE cycle after REPORT.
REQ-022 PROBE_IN SHALL be treated as synchronous to CLK; the block performs no synchronisation and no glitch filtering.
REQ-023 Minimum measurement latency (START sampled to DONE high):
  - Latency = QUIET_CYCLES + DELAY + 3 cycles.
  - BUSY is high from the cycle after START to DONE inclusive.

Reset
REQ-024 RST=1 at a rising edge SHALL force state IDLE and PROBE_OUT=0, BUSY=0, DONE=0, TIMEOUT=0, DELAY_OUT=0, and all counters to 0.
  - This applies in every state, including mid-FLUSH and mid-MEASURE.
REQ-025 RST SHALL take priority over START and over PROBE_IN on the same edge.
  - No DONE pulse is produced for an aborted measurement.

Verification
REQ-026 Combinational loopback (PROBE_IN=PROBE_OUT), START pulse -> DONE after 7 cycles (QUIET_CYCLES=4), DELAY_OUT=0, TIMEOUT=0.
REQ-027 Loop through a 12-stage shift register, then a 32-stage shift register, one measurement each -> DELAY_OUT=12 then 32, TIMEOUT=0 both times.
  - PROBE_OUT=0 in IDLE between the two runs.
REQ-028 PROBE_IN stuck at 0, MAX_DELAY=255 -> DONE with TIMEOUT=1 and DELAY_OUT=255.
REQ-029 PROBE_IN stuck at 1 -> FLUSH timeout after 259 cycles in FLUSH; DONE with TIMEOUT=1, DELAY_OUT=0; PROBE_OUT never rises.
REQ-030 Reset mid-operation:
  - Stimulus: 20-stage loop; RST asserted 5 cycles into MEASURE; then deassert and issue a new START.
  - Response: all outputs 0 the cycle after RST and no DONE pulse; the second run reports DELAY_OUT=20.
REQ-031 START re-asserted during FLUSH, MEASURE and REPORT -> no effect on counters or outputs; exactly one DONE per accepted START.
